// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, mode bit order and helpers for spi_sched
package spi_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int MODE_CPHA = 0;
  localparam int MODE_CPOL = 1;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    SETUP = 5'b00010,
    START = 5'b00100,
    BUSY  = 5'b01000,
    HOLD  = 5'b10000
  } state_t;
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/spi_rr_picker.sv
// spi_rr_picker: combinational round-robin pick of the first request at or above ptr, wrapping
module spi_rr_picker #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/spi_sched.sv
// spi_sched: round-robin scheduler sharing one SPI master among N requesters.
// Define SPI_SCHED_TIMEOUT_EN to add the BUSY watchdog that pulses Err.
module spi_sched import spi_pkg::*; #(
  parameter int N = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N-1:0]      Req,
  input  logic [N*DATA_W-1:0] TxData,
  input  logic [2*N-1:0]    CfgMode,
  output logic [N-1:0]      Gnt,
  output logic [N-1:0]      Done,
  output logic [N-1:0]      Err,
  output logic [DATA_W-1:0] RxData,
  output logic [N-1:0]      SS_n,
  output logic              StartTx,
  output logic [DATA_W-1:0] MosiData,
  output logic              CPol,
  output logic              CPha,
  input  logic              EndTx,
  input  logic [DATA_W-1:0] MisoData
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(max2(max2(SETUP_CYC, HOLD_CYC), TIMEOUT_CYC) + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr, idx, pick_idx;
  logic [N-1:0] pick_gnt;
  logic term, tmo, fin;
  spi_rr_picker #(.N(N), .PW(PW)) u_pick (.req(Req), .ptr(ptr), .gnt(pick_gnt), .idx(pick_idx));
`ifdef SPI_SCHED_TIMEOUT_EN
  assign tmo = state == BUSY && !EndTx && cnt == CW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  assign term = (state == SETUP && cnt == CW'(SETUP_CYC - 1)) || (state == HOLD && cnt == CW'(HOLD_CYC - 1));
  assign fin = state == BUSY && (EndTx || tmo);
  assign StartTx = state == START;
  always_comb begin
    nxt = state;
    nxt = (state == IDLE && |Req) ? SETUP :
          (state == SETUP && term) ? START :
          (state == START)         ? BUSY  :
          fin                      ? HOLD  :
          (state == HOLD && term)  ? IDLE  : state;
  end
  always_ff @(posedge Clk) state <= Rst ? IDLE : nxt;
  // cnt restarts on every state change and saturates at all-ones while waiting
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
      ptr <= '0;
      idx <= '0;
      Gnt <= '0;
      SS_n <= '1;
      Done <= '0;
      Err <= '0;
      RxData <= '0;
      MosiData <= '0;
      CPol <= 1'b0;
      CPha <= 1'b0;
    end else begin
      cnt <= (nxt != state) ? '0 : cnt + CW'(~&cnt);
      Done <= '0;
      Err <= '0;
      if (state == IDLE && |Req) begin
        idx <= pick_idx;
        Gnt <= pick_gnt;
        SS_n <= ~pick_gnt;
        MosiData <= TxData[pick_idx*DATA_W +: DATA_W];
        CPol <= CfgMode[2*pick_idx + MODE_CPOL];
        CPha <= CfgMode[2*pick_idx + MODE_CPHA];
      end
      if (fin) begin
        Gnt <= '0;
        SS_n <= '1;
        Done <= EndTx ? Gnt : '0;
        Err <= EndTx ? '0 : Gnt;
        RxData <= EndTx ? MisoData : RxData;
        ptr <= (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_sched.sv
// tb_spi_sched: directed self-checking bench for spi_sched (N=4, TIMEOUT_CYC=16).
// Exercises the watchdog path when SPI_SCHED_TIMEOUT_EN is defined.
module tb_spi_sched;
  logic Clk = 1'b0, Rst, EndTx, StartTx, CPol, CPha;
  logic [3:0] Req, Gnt, Done, Err, SS_n;
  logic [31:0] TxData;
  logic [7:0] CfgMode, RxData, MosiData, MisoData, rx_hold;
  int n_chk = 0, n_fail = 0;

  spi_sched #(.N(4), .DATA_W(8), .SETUP_CYC(2), .HOLD_CYC(2), .TIMEOUT_CYC(16)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .TxData(TxData), .CfgMode(CfgMode),
    .Gnt(Gnt), .Done(Done), .Err(Err), .RxData(RxData), .SS_n(SS_n),
    .StartTx(StartTx), .MosiData(MosiData), .CPol(CPol), .CPha(CPha),
    .EndTx(EndTx), .MisoData(MisoData)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (StartTx !== 1'b1 && t < 64) begin
      tick();
      t++;
    end
    check("start_seen", {31'd0, StartTx}, 32'd1);
  endtask

  // Stub master: EndTx five cycles after StartTx, then verify the Done cycle
  task automatic xfer(input logic [7:0] miso, input logic [3:0] exp_gnt);
    wait_start();
    check("gnt", {28'd0, Gnt}, {28'd0, exp_gnt});
    check("ss_sel", {28'd0, ~SS_n}, {28'd0, exp_gnt});
    check("ss_onehot", $countones(~SS_n), 32'd1);
    repeat (5) tick();
    EndTx = 1'b1;
    MisoData = miso;
    tick();
    EndTx = 1'b0;
    MisoData = 8'h00;
    check("done", {28'd0, Done}, {28'd0, exp_gnt});
    check("rx", {24'd0, RxData}, {24'd0, miso});
    check("err", {28'd0, Err}, 32'd0);
  endtask

  initial begin
    Rst = 1'b1;
    Req = 4'b0000;
    EndTx = 1'b0;
    MisoData = 8'h00;
    TxData = {8'h44, 8'hA5, 8'h22, 8'h11};
    CfgMode = {2'b00, 2'b10, 2'b01, 2'b11};
    tick();
    tick();
    check("rst_ss", {28'd0, SS_n}, 32'hF);
    check("rst_gnt", {28'd0, Gnt}, 32'd0);
    check("rst_start", {31'd0, StartTx}, 32'd0);
    check("rst_rx", {24'd0, RxData}, 32'd0);
    check("rst_mosi", {24'd0, MosiData}, 32'd0);
    check("rst_mode", {30'd0, CPol, CPha}, 32'd0);
    Rst = 1'b0;
    // Single request to requester 2, Req dropped right after grant
    Req = 4'b0100;
    tick();
    Req = 4'b0000;
    check("s_ss", {28'd0, SS_n}, 32'hB);
    check("s_gnt", {28'd0, Gnt}, 32'h4);
    check("s_mode", {30'd0, CPol, CPha}, 32'h2);
    check("s_mosi", {24'd0, MosiData}, 32'hA5);
    check("s_start_k1", {31'd0, StartTx}, 32'd0);
    tick();
    check("s_start_k2", {31'd0, StartTx}, 32'd0);
    tick();
    check("s_start_k3", {31'd0, StartTx}, 32'd1);
    tick();
    check("s_start_once", {31'd0, StartTx}, 32'd0);
    repeat (4) tick();
    EndTx = 1'b1;
    MisoData = 8'h3C;
    tick();
    EndTx = 1'b0;
    MisoData = 8'h00;
    check("s_done", {28'd0, Done}, 32'h4);
    check("s_rx", {24'd0, RxData}, 32'h3C);
    check("s_hold1_ss", {28'd0, SS_n}, 32'hF);
    Req = 4'b0001;
    tick();
    check("s_done_pulse", {28'd0, Done}, 32'd0);
    check("s_hold2_ss", {28'd0, SS_n}, 32'hF);
    check("s_hold_mosi", {24'd0, MosiData}, 32'hA5);
    tick();
    check("s_idle_ss", {28'd0, SS_n}, 32'hF);
    tick();
    check("s_next_gnt", {28'd0, SS_n}, 32'hE);
    Req = 4'b0000;
    xfer(8'h5A, 4'b0001);
    repeat (3) tick();
    // Contention from reset, then fairness wrap after serving 3
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    Req = 4'b1111;
    xfer(8'h01, 4'b0001);
    xfer(8'h02, 4'b0010);
    xfer(8'h03, 4'b0100);
    xfer(8'h04, 4'b1000);
    Req = 4'b1001;
    xfer(8'h05, 4'b0001);
    xfer(8'h06, 4'b1000);
    Req = 4'b1111;
    xfer(8'h07, 4'b0001);
    Req = 4'b0000;
    repeat (3) tick();
    // Withdrawal: Req[1] pulses while 0 is being served
    Req = 4'b0001;
    tick();
    Req = 4'b0010;
    tick();
    Req = 4'b0000;
    xfer(8'hC3, 4'b0001);
    repeat (6) tick();
    check("w_no_gnt", {28'd0, Gnt}, 32'd0);
    check("w_ss", {28'd0, SS_n}, 32'hF);
    // Reset during BUSY
    Req = 4'b0100;
    tick();
    Req = 4'b0000;
    wait_start();
    tick();
    tick();
    check("r_busy_ss", {28'd0, SS_n}, 32'hB);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("r_ss", {28'd0, SS_n}, 32'hF);
    check("r_gnt", {28'd0, Gnt}, 32'd0);
    check("r_done", {28'd0, Done}, 32'd0);
    check("r_rx", {24'd0, RxData}, 32'd0);
    check("r_mosi", {24'd0, MosiData}, 32'd0);
    check("r_mode", {30'd0, CPol, CPha}, 32'd0);
    EndTx = 1'b1;
    MisoData = 8'hFF;
    tick();
    EndTx = 1'b0;
    MisoData = 8'h00;
    check("r_stray_done", {28'd0, Done}, 32'd0);
    check("r_stray_rx", {24'd0, RxData}, 32'd0);
    // Watchdog behaviour: stub never raises EndTx
    Req = 4'b0001;
    tick();
    Req = 4'b0000;
    wait_start();
    rx_hold = RxData;
`ifdef SPI_SCHED_TIMEOUT_EN
    repeat (16) tick();
    check("t_no_err_yet", {28'd0, Err}, 32'd0);
    check("t_ss_busy", {28'd0, SS_n}, 32'hE);
    tick();
    check("t_err", {28'd0, Err}, 32'h1);
    check("t_done", {28'd0, Done}, 32'd0);
    check("t_rx", {24'd0, RxData}, {24'd0, rx_hold});
    check("t_hold_ss", {28'd0, SS_n}, 32'hF);
    tick();
    check("t_err_pulse", {28'd0, Err}, 32'd0);
`else
    repeat (40) tick();
    check("t_no_err", {28'd0, Err}, 32'd0);
    check("t_still_busy", {28'd0, Gnt}, 32'h1);
    EndTx = 1'b1;
    MisoData = 8'h99;
    tick();
    EndTx = 1'b0;
    check("t_late_done", {28'd0, Done}, 32'h1);
    check("t_late_rx", {24'd0, RxData}, 32'h99);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
